// File: rtl/hazard_pkg.sv
// hazard_pkg: shared widths, forward-source constants and scoreboard entry type for hazard_ctrl
package hazard_pkg;

    localparam int TW = 2;
    localparam int RW = 5;

    localparam int FWD_GRF = 0;
    localparam int ST_E    = 1;
    localparam int ST_M    = 2;
    localparam int ST_W    = 3;

    typedef struct packed {
        logic          v;
        logic [RW-1:0] a3;
        logic [TW-1:0] tnew;
    } sb_entry_t;

    // One pipeline step older: remaining Tnew drops by one and sticks at zero.
    function automatic sb_entry_t sb_age(sb_entry_t e);
        sb_entry_t r;
        r      = e;
        r.tnew = (e.tnew == '0) ? '0 : e.tnew - 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: D-stage hazard query bundle between the decode stage and hazard_ctrl
import hazard_pkg::*;

interface hazard_ctrl_if #(
    parameter int NSTAGE = 3,
    parameter int TW     = hazard_pkg::TW,
    parameter int RW     = hazard_pkg::RW
);
    localparam int FW = $clog2(NSTAGE + 1);

    logic          d_valid;
    logic [RW-1:0] d_a1;
    logic [RW-1:0] d_a2;
    logic [TW-1:0] d_tuse1;
    logic [TW-1:0] d_tuse2;
    logic [RW-1:0] d_a3;
    logic [TW-1:0] d_tnew;
    logic          d_md_start;
    logic          d_md_div;
    logic          d_md_use;
    logic          stall;
    logic [FW-1:0] fwd1_sel;
    logic [FW-1:0] fwd2_sel;
    logic          md_busy;

    modport master (
        output d_valid, d_a1, d_a2, d_tuse1, d_tuse2, d_a3, d_tnew,
               d_md_start, d_md_div, d_md_use,
        input  stall, fwd1_sel, fwd2_sel, md_busy
    );

    modport slave (
        input  d_valid, d_a1, d_a2, d_tuse1, d_tuse2, d_a3, d_tnew,
               d_md_start, d_md_div, d_md_use,
        output stall, fwd1_sel, fwd2_sel, md_busy
    );

endinterface

// File: rtl/md_busy_counter.sv
// md_busy_counter: down-counter that keeps the mult/div unit marked busy after a start
module md_busy_counter #(
    parameter int MULT_CYC = 5,
    parameter int DIV_CYC  = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic is_div,
    output logic busy
);
    localparam int CW = $clog2(DIV_CYC + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // Load on an accepted start, otherwise count down to zero and hold.
    always_comb begin
        cnt_d = start ? (is_div ? CW'(DIV_CYC) : CW'(MULT_CYC))
                      : (cnt_q != '0 ? cnt_q - 1'b1 : cnt_q);
    end

    // Counter register; reset abandons any running operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign busy = (cnt_q != '0);

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: scoreboard-based stall and D-stage forward-select controller with MD busy tracking
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int NSTAGE   = 3,
    parameter int TW       = hazard_pkg::TW,
    parameter int RW       = hazard_pkg::RW,
    parameter int MULT_CYC = 5,
    parameter int DIV_CYC  = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    hazard_ctrl_if.slave  hz
);
    localparam int FW = $clog2(NSTAGE + 1);

    sb_entry_t     sb_q [1:NSTAGE];
    sb_entry_t     sb_d [1:NSTAGE];
    logic [NSTAGE:1] hit1, hit2;
    logic [RW-1:0] a1, a2;
    logic [FW-1:0] k1, k2;
    logic [TW-1:0] t1, t2;
    logic          st1, st2, stall_md, md_start;

    assign a1 = hz.d_a1;
    assign a2 = hz.d_a2;

    // Stage 1 takes the D instruction (or a bubble when stalled); older stages age by one.
    assign sb_d[ST_E] = '{v:    hz.d_valid & ~hz.stall & (hz.d_a3 != '0),
                          a3:   hz.d_a3,
                          tnew: hz.d_tnew};

    for (genvar k = 2; k <= NSTAGE; k++) begin : g_shift
        assign sb_d[k] = sb_age(sb_q[k-1]);
    end

    for (genvar k = 1; k <= NSTAGE; k++) begin : g_hit
        assign hit1[k] = sb_q[k].v && (sb_q[k].a3 == a1) && (a1 != '0);
        assign hit2[k] = sb_q[k].v && (sb_q[k].a3 == a2) && (a2 != '0);
    end

    // Scoreboard register; reset empties every stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 1; k <= NSTAGE; k++) sb_q[k] <= '0;
        end else begin
            for (int k = 1; k <= NSTAGE; k++) sb_q[k] <= sb_d[k];
        end
    end

    // Youngest matching stage wins: scan oldest to youngest so the last write sticks.
    always_comb begin
        k1 = '0;
        k2 = '0;
        t1 = '0;
        t2 = '0;
        for (int k = NSTAGE; k >= 1; k--) begin
            if (hit1[k]) begin
                k1 = FW'(k);
                t1 = sb_q[k].tnew;
            end
            if (hit2[k]) begin
                k2 = FW'(k);
                t2 = sb_q[k].tnew;
            end
        end
    end

    // Stall when a producer is not ready in time or HI/LO is still being computed; forward only ready results.
    always_comb begin
        st1         = (k1 != '0) && (t1 > hz.d_tuse1);
        st2         = (k2 != '0) && (t2 > hz.d_tuse2);
        stall_md    = hz.d_valid & (hz.d_md_start | hz.d_md_use) & hz.md_busy;
        hz.stall    = hz.d_valid & (st1 | st2 | stall_md);
        hz.fwd1_sel = (!hz.stall && k1 != '0 && t1 == '0) ? k1 : FW'(FWD_GRF);
        hz.fwd2_sel = (!hz.stall && k2 != '0 && t2 == '0) ? k2 : FW'(FWD_GRF);
    end

    assign md_start = hz.d_valid & hz.d_md_start & ~hz.stall;

    md_busy_counter #(
        .MULT_CYC (MULT_CYC),
        .DIV_CYC  (DIV_CYC)
    ) u_md (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (md_start),
        .is_div (hz.d_md_div),
        .busy   (hz.md_busy)
    );

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed and random checks of hazard_ctrl against a cycle-age reference model
import hazard_pkg::*;

module tb_hazard_ctrl;

    localparam int NSTAGE   = 3;
    localparam int MULT_CYC = 5;
    localparam int DIV_CYC  = 10;

    typedef struct {
        bit v;
        int a3;
        int tnew;
        int birth;
    } ment_t;

    logic clk;
    logic rst_n;
    int   tests, fails;
    int   cyc, busy_until;
    int   exp_stall, exp_f1, exp_f2, exp_busy;
    ment_t pipe[$];

    hazard_ctrl_if #(.NSTAGE(NSTAGE)) hz ();

    hazard_ctrl #(
        .NSTAGE   (NSTAGE),
        .MULT_CYC (MULT_CYC),
        .DIV_CYC  (DIV_CYC)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (hz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic void model_reset();
        pipe.delete();
        for (int i = 0; i < NSTAGE; i++) pipe.push_back('{0, 0, 0, 0});
        busy_until = -1;
    endfunction

    // Remaining latency = original Tnew minus cycles spent since entering E, floored at zero.
    function automatic int remain(ment_t e);
        int age = cyc - e.birth;
        return (e.tnew > age) ? e.tnew - age : 0;
    endfunction

    function automatic int find(int a);
        if (a == 0) return -1;
        for (int j = 0; j < NSTAGE; j++)
            if (pipe[j].v && pipe[j].a3 == a) return j;
        return -1;
    endfunction

    function automatic void eval();
        int j1 = find(int'(hz.d_a1));
        int j2 = find(int'(hz.d_a2));
        bit s1 = (j1 >= 0) && (remain(pipe[j1 < 0 ? 0 : j1]) > int'(hz.d_tuse1));
        bit s2 = (j2 >= 0) && (remain(pipe[j2 < 0 ? 0 : j2]) > int'(hz.d_tuse2));
        exp_busy  = (cyc <= busy_until) ? 1 : 0;
        exp_stall = (hz.d_valid && (s1 || s2 || (exp_busy == 1 && (hz.d_md_start || hz.d_md_use)))) ? 1 : 0;
        exp_f1 = (exp_stall == 0 && j1 >= 0 && remain(pipe[j1 < 0 ? 0 : j1]) == 0) ? j1 + 1 : 0;
        exp_f2 = (exp_stall == 0 && j2 >= 0 && remain(pipe[j2 < 0 ? 0 : j2]) == 0) ? j2 + 1 : 0;
    endfunction

    function automatic void advance();
        bit acc = hz.d_valid && exp_stall == 0;
        pipe.push_front('{acc && hz.d_a3 != 0, int'(hz.d_a3), int'(hz.d_tnew), cyc + 1});
        void'(pipe.pop_back());
        if (acc && hz.d_md_start) busy_until = cyc + (hz.d_md_div ? DIV_CYC : MULT_CYC);
    endfunction

    task automatic drv(input bit v, input int a1, input int a2, input int t1, input int t2,
                       input int a3, input int tn, input bit ms, input bit md, input bit mu);
        hz.d_valid    = v;
        hz.d_a1       = 5'(a1);
        hz.d_a2       = 5'(a2);
        hz.d_tuse1    = 2'(t1);
        hz.d_tuse2    = 2'(t2);
        hz.d_a3       = 5'(a3);
        hz.d_tnew     = 2'(tn);
        hz.d_md_start = ms;
        hz.d_md_div   = md;
        hz.d_md_use   = mu;
    endtask

    task automatic step();
        #1;
        eval();
        chk("stall", hz.stall, 8'(exp_stall));
        chk("fwd1_sel", 8'(hz.fwd1_sel), 8'(exp_f1));
        chk("fwd2_sel", 8'(hz.fwd2_sel), 8'(exp_f2));
        chk("md_busy", hz.md_busy, 8'(exp_busy));
        @(posedge clk);
        if (!rst_n) model_reset();
        else        advance();
        cyc++;
        @(negedge clk);
    endtask

    task automatic flush();
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (NSTAGE + 1) step();
    endtask

    initial begin
        tests = 0;
        fails = 0;
        cyc   = 0;
        rst_n = 1'b0;
        model_reset();
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst_stall", hz.stall, 8'd0);
        chk("rst_fwd1", 8'(hz.fwd1_sel), 8'd0);
        chk("rst_fwd2", 8'(hz.fwd2_sel), 8'd0);
        chk("rst_busy", hz.md_busy, 8'd0);
        @(negedge clk);
        rst_n = 1'b1;
        flush();

        // lw $8 then addu reading $8 with tuse=1
        drv(1, 0, 0, 0, 0, 8, 2, 0, 0, 0);
        step();
        drv(1, 8, 0, 1, 0, 10, 1, 0, 0, 0);
        #1 chk("t1_stall_on", hz.stall, 8'd1);
        step();
        #1 chk("t1_stall_off", hz.stall, 8'd0);
        step();
        flush();

        // addu $9 then beq on $9 with tuse=0
        drv(1, 0, 0, 0, 0, 9, 1, 0, 0, 0);
        step();
        drv(1, 9, 0, 0, 0, 0, 0, 0, 0, 0);
        #1 chk("t2_stall_on", hz.stall, 8'd1);
        step();
        #1 chk("t2_stall_off", hz.stall, 8'd0);
        chk("t2_fwd_m", 8'(hz.fwd1_sel), 8'(ST_M));
        step();
        flush();

        // write to $0 never matches
        drv(1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        step();
        drv(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1 chk("t3_stall", hz.stall, 8'd0);
        chk("t3_fwd", 8'(hz.fwd1_sel), 8'(FWD_GRF));
        step();
        flush();

        // $5 in stages 1 and 3, $6 in stage 2: youngest $5 wins
        drv(1, 0, 0, 0, 0, 5, 0, 0, 0, 0);
        step();
        drv(1, 0, 0, 0, 0, 6, 0, 0, 0, 0);
        step();
        drv(1, 0, 0, 0, 0, 5, 0, 0, 0, 0);
        step();
        drv(1, 5, 6, 0, 0, 0, 0, 0, 0, 0);
        #1 chk("t4_fwd_young", 8'(hz.fwd1_sel), 8'(ST_E));
        chk("t4_fwd2", 8'(hz.fwd2_sel), 8'(ST_M));
        step();
        drv(1, 6, 0, 0, 0, 0, 0, 0, 0, 0);
        #1 chk("t4_fwd_w", 8'(hz.fwd1_sel), 8'(ST_W));
        step();
        flush();

        // div accepted, mfhi waits out the whole busy window
        drv(1, 0, 0, 0, 0, 0, 0, 1, 1, 0);
        #1 chk("t5_busy_pre", hz.md_busy, 8'd0);
        chk("t5_stall_pre", hz.stall, 8'd0);
        step();
        drv(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < DIV_CYC; i++) begin
            #1 chk("t5_busy", hz.md_busy, 8'd1);
            chk("t5_stall", hz.stall, 8'd1);
            step();
        end
        #1 chk("t5_busy_end", hz.md_busy, 8'd0);
        chk("t5_stall_end", hz.stall, 8'd0);
        step();
        flush();

        // asynchronous reset mid-div with a pending producer
        drv(1, 0, 0, 0, 0, 0, 0, 1, 1, 0);
        step();
        drv(1, 0, 0, 0, 0, 7, 2, 0, 0, 0);
        step();
        drv(1, 7, 0, 0, 0, 0, 0, 0, 0, 1);
        #1 chk("t6_stall_pre", hz.stall, 8'd1);
        #1 rst_n = 1'b0;
        #1 model_reset();
        chk("t6_stall_rst", hz.stall, 8'd0);
        chk("t6_busy_rst", hz.md_busy, 8'd0);
        chk("t6_fwd_rst", 8'(hz.fwd1_sel), 8'd0);
        step();
        rst_n = 1'b1;
        #1 chk("t6_resume", hz.stall, 8'd0);
        step();
        drv(1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        step();
        flush();

        // random traffic; a stalled instruction stays in D unchanged
        for (int n = 0; n < 400; n++) begin
            if (exp_stall == 0 || n == 0) begin
                drv($urandom_range(5, 0) != 0,
                    $urandom_range(7, 0), $urandom_range(7, 0),
                    $urandom_range(3, 0), $urandom_range(3, 0),
                    $urandom_range(7, 0), $urandom_range(3, 0),
                    $urandom_range(7, 0) == 0, $urandom_range(1, 0) != 0,
                    $urandom_range(5, 0) == 0);
            end
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
